// File: rtl/cluster_truncate_ctrl_pkg.sv
// Shared definitions for the cluster truncator sequencer: state encoding,
// truncator base load latency and the default number of cluster slots.
package cluster_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_LOAD = 2'd1,
    EXTRACT   = 2'd2
  } ctrl_state_e;

  // Cycles from latch_in to new data at the truncator output with zero delay.
  localparam int TRUNC_LOAD_LAT = 2;

  localparam int MXCLUSTERS_DEF = 8;

endpackage

// File: rtl/cluster_truncate_ctrl_if.sv
// Truncator / priority-encoder side of the cluster sequencer.
// master: the sequencer; slave: the truncator/encoder pair.
interface cluster_truncate_ctrl_if #(
  parameter int IDX_W = 3
);
  logic             latch_in;
  logic [3:0]       latch_delay;
  logic             trunc_active;
  logic             cluster_valid;
  logic [IDX_W-1:0] cluster_index;

  modport master (
    output latch_in, latch_delay, cluster_valid, cluster_index,
    input  trunc_active
  );

  modport slave (
    input  latch_in, latch_delay, cluster_valid, cluster_index,
    output trunc_active
  );
endinterface

// File: rtl/cluster_truncate_ctrl_sat_counter.sv
// Saturating event counter used for the sequencer statistics.
// Only compiled when CLUSTER_CTRL_STATS_EN is defined, since it has no
// other user.
`ifdef CLUSTER_CTRL_STATS_EN
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  // Count up on inc, sticking at all-ones.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule
`endif

// File: rtl/cluster_truncate_ctrl.sv
// Sequencer for the 768-bit cluster truncator and its priority encoder.
// Issues the truncator load strobe once per frame, waits out the load
// latency, then qualifies one cluster slot per clock while the truncator
// still holds set bits, flagging overflow when slots run out.
// Optional statistics counters: define CLUSTER_CTRL_STATS_EN.
module cluster_truncate_ctrl
  import cluster_ctrl_pkg::*;
#(
  parameter int MXCLUSTERS = MXCLUSTERS_DEF,
  parameter int IDX_W      = 3,
  parameter int STAT_W     = 16
) (
  input  logic                    clock,
  input  logic                    global_reset_n,
  input  logic                    frame_start,
  input  logic                    ctrl_enable,
  input  logic [3:0]              latch_delay_cfg,
  cluster_truncate_ctrl_if.master trunc_bus,
  output logic                    frame_done,
  output logic                    overflow,
  output logic                    busy,
  output logic [STAT_W-1:0]       frame_count,
  output logic [STAT_W-1:0]       overflow_count
);

  localparam logic [IDX_W:0] SLOT_MAX = (IDX_W+1)'(MXCLUSTERS);

  ctrl_state_e    state;
  logic [4:0]     wait_cnt;
  logic [IDX_W:0] slot;
  logic           latch_r;
  logic [3:0]     delay_r;

  logic           start;
  logic           in_extract;
  logic           slot_ok;
  logic [3:0]     eff_delay;

  assign start      = frame_start & ctrl_enable;
  assign in_extract = (state == EXTRACT);
  assign slot_ok    = (slot < SLOT_MAX);
  // In IDLE the shadow is about to capture the config, so a frame started
  // now must wait on that same value; otherwise the frozen shadow applies.
  assign eff_delay  = (state == IDLE) ? latch_delay_cfg : delay_r;

  // Per-cycle qualification of the truncator output while extracting.
  always_comb begin
    trunc_bus.cluster_valid = in_extract & trunc_bus.trunc_active & slot_ok;
    trunc_bus.cluster_index = '0;
    if (trunc_bus.cluster_valid) begin
      trunc_bus.cluster_index = slot[IDX_W-1:0];
    end
    frame_done = in_extract & (start | ~trunc_bus.trunc_active | ~slot_ok);
    overflow   = in_extract & trunc_bus.trunc_active & (start | ~slot_ok);
  end

  assign busy                  = (state != IDLE);
  assign trunc_bus.latch_in    = latch_r;
  assign trunc_bus.latch_delay = delay_r;

  // Frame sequencer: IDLE -> WAIT_LOAD -> EXTRACT, restartable by frame_start.
  always_ff @(posedge clock or negedge global_reset_n) begin
    if (!global_reset_n) begin
      state    <= IDLE;
      wait_cnt <= '0;
      slot     <= '0;
      latch_r  <= 1'b0;
      delay_r  <= '0;
    end else begin
      latch_r <= start;
      if (state == IDLE) begin
        delay_r <= latch_delay_cfg;
      end
      if (start) begin
        state    <= WAIT_LOAD;
        wait_cnt <= {1'b0, eff_delay} + 5'(TRUNC_LOAD_LAT);
        slot     <= '0;
      end else begin
        case (state)
          IDLE: ;
          WAIT_LOAD: begin
            if (wait_cnt == 5'd1) begin
              state <= EXTRACT;
              slot  <= '0;
            end else begin
              wait_cnt <= wait_cnt - 5'd1;
            end
          end
          EXTRACT: begin
            if (!trunc_bus.trunc_active || !slot_ok) begin
              state <= IDLE;
            end else begin
              slot <= slot + (IDX_W+1)'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef CLUSTER_CTRL_STATS_EN
  sat_counter #(.WIDTH(STAT_W)) u_frame_cnt (
    .clock (clock),
    .rst_n (global_reset_n),
    .inc   (frame_done),
    .count (frame_count)
  );

  sat_counter #(.WIDTH(STAT_W)) u_ovf_cnt (
    .clock (clock),
    .rst_n (global_reset_n),
    .inc   (overflow),
    .count (overflow_count)
  );
`else
  assign frame_count    = '0;
  assign overflow_count = '0;
`endif

endmodule

// File: tb/tb_cluster_truncate_ctrl.sv
// Bench for cluster_truncate_ctrl: frames are described by (delay, number of
// clusters the truncator holds, optional preempt cycle) and the expected
// per-cycle outputs are derived from that description.
module tb_cluster_truncate_ctrl;

  localparam int MX     = 8;
  localparam int IDX_W  = 3;
  localparam int STAT_W = 16;

  logic              clock = 1'b0;
  logic              global_reset_n = 1'b0;
  logic              frame_start = 1'b0;
  logic              ctrl_enable = 1'b0;
  logic [3:0]        latch_delay_cfg = 4'd0;
  logic              frame_done, overflow, busy;
  logic [STAT_W-1:0] frame_count, overflow_count;

  int checks = 0;
  int failures = 0;
  int exp_frames = 0;
  int exp_ovfs = 0;

  cluster_truncate_ctrl_if #(.IDX_W(IDX_W)) bus ();

  cluster_truncate_ctrl #(.MXCLUSTERS(MX), .IDX_W(IDX_W), .STAT_W(STAT_W)) dut (
    .clock           (clock),
    .global_reset_n  (global_reset_n),
    .frame_start     (frame_start),
    .ctrl_enable     (ctrl_enable),
    .latch_delay_cfg (latch_delay_cfg),
    .trunc_bus       (bus.master),
    .frame_done      (frame_done),
    .overflow        (overflow),
    .busy            (busy),
    .frame_count     (frame_count),
    .overflow_count  (overflow_count)
  );

  always #5 clock = ~clock;

  function automatic logic [STAT_W-1:0] cnt_exp(input int v);
`ifdef CLUSTER_CTRL_STATS_EN
    return STAT_W'(v);
`else
    return STAT_W'(v * 0);
`endif
  endfunction

  function automatic logic [11:0] observe();
    return {bus.latch_in, bus.latch_delay, bus.cluster_valid, bus.cluster_index,
            frame_done, overflow, busy};
  endfunction

  // Checks every cycle of a frame whose start edge has just occurred.
  // A frame with delay d reaches extraction d+3 cycles after the start edge;
  // the truncator holds n clusters, so min(n,MX) are qualified and the frame
  // ends on the following extraction cycle. pk>0 issues a new start at cycle pk.
  task automatic follow_frame(input int d, input int n, input int new_cfg,
                              input int pk, input string tag);
    int ke, m, e;
    bit preempted;
    logic ev, ed, eo;
    logic [2:0] ei;
    logic [11:0] obs, exp_v;
    ke = d + 3;
    m = (n < MX) ? n : MX;
    preempted = 1'b0;
    for (int k = 1; k <= ke + m + 1; k++) begin
      @(posedge clock); #1;
      e = k - ke;
      if (k == pk) begin
        frame_start = 1'b1; ctrl_enable = 1'b1;
      end else begin
        frame_start = ($urandom % 3 == 0); ctrl_enable = 1'b0;
      end
      bus.trunc_active = (e < 0) ? 1'($urandom % 2) : (e < n);
      if (e == 0 && new_cfg >= 0) latch_delay_cfg = 4'(new_cfg);
      #1;
      ev = (e >= 0) && (e < m);
      ei = ev ? 3'(e) : 3'd0;
      ed = (e == m) || (k == pk && e >= 0);
      eo = ed && (e < n);
      exp_v = {(k == 1), 4'(d), ev, ei, ed, eo, (e <= m)};
      obs = observe();
      checks++;
      if (obs !== exp_v) begin
        failures++;
        $display("FAIL %s k=%0d {latch,dly,vld,idx,done,ovf,busy} got=%b want=%b",
                 tag, k, obs, exp_v);
      end
      if (ed) exp_frames++;
      if (eo) exp_ovfs++;
      if (k == pk) begin
        preempted = 1'b1;
        break;
      end
    end
    if (!preempted) begin
      frame_start = 1'b0;
      bus.trunc_active = 1'b0;
      checks++;
      if (frame_count !== cnt_exp(exp_frames) || overflow_count !== cnt_exp(exp_ovfs)) begin
        failures++;
        $display("FAIL %s_counters got=%0d/%0d want=%0d/%0d", tag, frame_count,
                 overflow_count, cnt_exp(exp_frames), cnt_exp(exp_ovfs));
      end
    end
  endtask

  task automatic run_frame(input int d, input int n, input int new_cfg,
                           input int pk, input string tag);
    latch_delay_cfg = 4'(d);
    frame_start = 1'b0; ctrl_enable = 1'b0; bus.trunc_active = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    frame_start = 1'b1; ctrl_enable = 1'b1;
    follow_frame(d, n, new_cfg, pk, tag);
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (observe() !== 12'd0 || frame_count !== '0 || overflow_count !== '0) begin
      failures++;
      $display("FAIL reset got=%b cnt=%0d/%0d want=0", observe(), frame_count, overflow_count);
    end
    @(posedge clock); #1;
    global_reset_n = 1'b1;
  endtask

  task automatic test_short_frame();
    run_frame(0, 3, -1, 0, "short_d0_n3");
  endtask

  task automatic test_overflow_frame();
    run_frame(15, 12, -1, 0, "ovf_d15");
  endtask

  task automatic test_empty_frame();
    run_frame(4, 0, -1, 0, "empty");
  endtask

  task automatic test_cfg_shadow();
    run_frame(3, 4, 7, 0, "cfg_shadow");
    repeat (2) @(posedge clock);
    #1;
    checks++;
    if (bus.latch_delay !== 4'd7) begin
      failures++;
      $display("FAIL cfg_shadow_idle latch_delay got=%0d want=7", bus.latch_delay);
    end
  endtask

  task automatic test_preempt();
    // Second start at extraction slot 2 (delay 2 -> extraction from k=5).
    run_frame(2, 10, -1, 7, "preempt_a");
    follow_frame(2, 2, -1, 0, "preempt_b");
  endtask

  task automatic test_back_to_back();
    run_frame(5, 3, -1, 3, "restart_wait");
    follow_frame(5, 3, -1, 0, "restart_follow");
  endtask

  task automatic test_disabled();
    frame_start = 1'b1; ctrl_enable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clock); #2;
      checks++;
      if (bus.latch_in !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b0) begin
        failures++;
        $display("FAIL disabled cyc=%0d latch=%b busy=%b done=%b want=0", i,
                 bus.latch_in, busy, frame_done);
      end
    end
    frame_start = 1'b0;
  endtask

  task automatic test_reset_midframe();
    latch_delay_cfg = 4'd6;
    repeat (2) @(posedge clock);
    #1;
    frame_start = 1'b1; ctrl_enable = 1'b1;
    @(posedge clock); #1;
    frame_start = 1'b0; ctrl_enable = 1'b0;
    @(posedge clock); #1;
    global_reset_n = 1'b0;
    #1;
    exp_frames = 0; exp_ovfs = 0;
    checks++;
    if (observe() !== 12'd0 || frame_count !== '0 || overflow_count !== '0) begin
      failures++;
      $display("FAIL reset_midframe got=%b cnt=%0d/%0d want=0", observe(),
               frame_count, overflow_count);
    end
    @(posedge clock); #1;
    global_reset_n = 1'b1;
    run_frame(1, 5, -1, 0, "after_reset");
  endtask

  task automatic test_random();
    int d, n, ncfg, pk, m;
    for (int i = 0; i < 25; i++) begin
      d = $urandom_range(0, 15);
      n = $urandom_range(0, 11);
      m = (n < MX) ? n : MX;
      ncfg = ($urandom % 3 == 0) ? int'($urandom_range(0, 15)) : -1;
      pk = ($urandom % 4 == 0) ? int'($urandom_range(1, d + 3 + m)) : 0;
      run_frame(d, n, ncfg, pk, "rand");
      if (pk != 0) follow_frame(d, $urandom_range(0, 11), -1, 0, "rand_follow");
    end
  endtask

  initial begin
    test_reset();
    test_short_frame();
    test_overflow_frame();
    test_empty_frame();
    test_cfg_shadow();
    test_preempt();
    test_back_to_back();
    test_disabled();
    test_reset_midframe();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
